// File: rtl/stacker_pkg.sv
// Shared definitions for the block stacker: FSM encoding, default sizing
// constants and small integer helpers used by the sequencer and slider datapath.
package stacker_pkg;

    typedef enum logic [1:0] {
        S_WAIT = 2'd0,
        S_PLAY = 2'd1,
        S_WON  = 2'd2,
        S_LOST = 2'd3
    } state_t;

    localparam int DEF_NUM_LEVELS = 15;
    localparam int DEF_MAX_BLOCKS = 3;

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int max_i(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Clamp v to the largest value representable in an unsigned field of width w.
    function automatic int sat_w(input int v, input int w);
        return min_i(v, (1 << w) - 1);
    endfunction

endpackage

// File: rtl/level_cap_counter.sv
// Row-width cap schedule: the cap drops by one (never below 1) every
// SHRINK_EVERY cleared levels.
module level_cap_counter
    import stacker_pkg::*;
#(
    parameter int MAX_BLOCKS   = DEF_MAX_BLOCKS,
    parameter int SHRINK_EVERY = 5,
    parameter int BLK_W        = 3
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clear,
    input  logic             step,
    output logic [BLK_W-1:0] cap,
    output logic             shrink_due
);

    localparam int CNT_W = (SHRINK_EVERY > 1) ? $clog2(SHRINK_EVERY) : 1;

    logic [CNT_W-1:0] shrink_cnt;
    logic [BLK_W-1:0] cap_dec;

    // shrink_due: the next step completes a SHRINK_EVERY group.
    assign shrink_due = (shrink_cnt == CNT_W'(SHRINK_EVERY - 1));
    assign cap_dec    = BLK_W'(max_i(int'(cap) - 1, 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            shrink_cnt <= '0;
            cap        <= BLK_W'(MAX_BLOCKS);
        end else if (clear) begin
            shrink_cnt <= '0;
            cap        <= BLK_W'(MAX_BLOCKS);
        end else if (step) begin
            if (shrink_due) begin
                shrink_cnt <= '0;
                cap        <= cap_dec;
            end else begin
                shrink_cnt <= shrink_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/level_sequencer.sv
// Game-progression controller for the block stacker: level, slider speed and
// moving-row width, with win/loss detection and restart.
module level_sequencer
    import stacker_pkg::*;
#(
    parameter int NUM_LEVELS   = DEF_NUM_LEVELS,
    parameter int LVL_W        = 4,
    parameter int SPEED_W      = 4,
    parameter int BLK_W        = 3,
    parameter int MAX_BLOCKS   = DEF_MAX_BLOCKS,
    parameter int SHRINK_EVERY = 5,
    parameter bit AUTO_ADVANCE = 1'b0
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               go,
    input  logic               place_valid,
    input  logic [BLK_W-1:0]   place_width,
    output logic [LVL_W-1:0]   level,
    output logic [SPEED_W-1:0] speed,
    output logic [BLK_W-1:0]   num_blocks,
    output logic               active,
    output logic               game_won,
    output logic               game_over
);

    state_t             state, state_next;
    logic [LVL_W-1:0]   level_next;
    logic [SPEED_W-1:0] speed_next;
    logic [BLK_W-1:0]   blocks_next;
    logic [BLK_W-1:0]   eff_w;
    logic [BLK_W-1:0]   cap, cap_after;
    logic               shrink_due;
    logic               cap_clear, cap_step;

    level_cap_counter #(
        .MAX_BLOCKS   (MAX_BLOCKS),
        .SHRINK_EVERY (SHRINK_EVERY),
        .BLK_W        (BLK_W)
    ) u_cap (
        .clk        (clk),
        .resetn     (resetn),
        .clear      (cap_clear),
        .step       (cap_step),
        .cap        (cap),
        .shrink_due (shrink_due)
    );

    // A drop wider than the moving row can only land as many blocks as the row has.
    assign eff_w     = BLK_W'(min_i(int'(place_width), int'(num_blocks)));
    assign cap_after = shrink_due ? BLK_W'(max_i(int'(cap) - 1, 1)) : cap;

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_next  = state;
        level_next  = level;
        speed_next  = speed;
        blocks_next = num_blocks;
        cap_clear   = 1'b0;
        cap_step    = 1'b0;

        unique case (state)
            S_WAIT: begin
                if (go) state_next = S_PLAY;
            end
            S_PLAY: begin
                if (place_valid) begin
                    if (eff_w == '0) begin
                        state_next = S_LOST;
                    end else if (level == LVL_W'(NUM_LEVELS)) begin
                        state_next = S_WON;
                    end else begin
                        level_next  = level + LVL_W'(1);
                        speed_next  = SPEED_W'(sat_w(int'(level) + 1, SPEED_W));
                        blocks_next = BLK_W'(min_i(int'(eff_w), int'(cap_after)));
                        cap_step    = 1'b1;
                        state_next  = AUTO_ADVANCE ? S_PLAY : S_WAIT;
                    end
                end
            end
            S_WON, S_LOST: begin
                if (go) begin
                    level_next  = LVL_W'(1);
                    speed_next  = SPEED_W'(1);
                    blocks_next = BLK_W'(MAX_BLOCKS);
                    cap_clear   = 1'b1;
                    state_next  = S_PLAY;
                end
            end
            default: state_next = S_WAIT;
        endcase
    end

    // NOTE: asynchronous reset takes effect without a clock edge, so a reset
    // mid-level discards any advance that was about to be registered.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= S_WAIT;
            level      <= LVL_W'(1);
            speed      <= SPEED_W'(1);
            num_blocks <= BLK_W'(MAX_BLOCKS);
        end else begin
            state      <= state_next;
            level      <= level_next;
            speed      <= speed_next;
            num_blocks <= blocks_next;
        end
    end

    assign active    = (state == S_PLAY);
    assign game_won  = (state == S_WON);
    assign game_over = (state == S_LOST);

endmodule
